eeprom_arbiter: RTL

EEPROM_ARBITER -- requirements
Module: eeprom_arbiter

---
 rtl/eeprom_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/eeprom_arbiter.sv
// Two-port round-robin arbiter in front of a single EEPROM controller.
// One transaction is in flight at a time: grant, issue pulse, wait for ACK or timeout, done pulse.
module eeprom_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [10:0] ADDR0,
    input  logic [10:0] ADDR1,
    input  logic [7:0]  WDATA0,
    input  logic [7:0]  WDATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        ERR,
    output logic [7:0]  RDATA,
    output logic        EE_WR,
    output logic        EE_RD,
    output logic [10:0] EE_ADDR,
    output logic [7:0]  EE_DOUT,
    output logic        EE_DOE,
    input  logic [7:0]  EE_DIN,
    input  logic        EE_ACK
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        last_q;
    logic        we_q;
    logic [9:0]  cnt_q;

    logic        elig0;
    logic        elig1;
    logic        pick1;
    logic        any_elig;
    logic        timeout_hit;
    logic        win_we;
    logic [10:0] win_addr;
    logic [7:0]  win_wdata;

    always_comb begin
        elig0       = REQ0 & ~DONE0;
        elig1       = REQ1 & ~DONE1;
        // On a tie the requester that did not win last time is chosen.
        pick1       = elig1 & (~elig0 | ~last_q);
        any_elig    = elig0 | elig1;
        win_we      = pick1 ? WE1 : WE0;
        win_addr    = pick1 ? ADDR1 : ADDR0;
        win_wdata   = pick1 ? WDATA1 : WDATA0;
        timeout_hit = (cnt_q == TIMEOUT_CNT);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_elig) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (EE_ACK || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= 10'd0;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            DONE0   <= 1'b0;
            DONE1   <= 1'b0;
            ERR     <= 1'b0;
            RDATA   <= 8'h00;
            EE_WR   <= 1'b0;
            EE_RD   <= 1'b0;
            EE_ADDR <= 11'h000;
            EE_DOUT <= 8'h00;
            EE_DOE  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        GNT0    <= ~pick1;
                        GNT1    <= pick1;
                        last_q  <= pick1;
                        we_q    <= win_we;
                        EE_ADDR <= win_addr;
                        EE_DOUT <= win_wdata;
                        EE_WR   <= win_we;
                        EE_RD   <= ~win_we;
                        EE_DOE  <= win_we;
                    end
                end
                S_ISSUE: begin
                    EE_WR <= 1'b0;
                    EE_RD <= 1'b0;
                    cnt_q <= 10'd0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 10'd1;
                    // ACK takes priority over a timeout landing in the same cycle.
                    if (EE_ACK || timeout_hit) begin
                        ERR    <= ~EE_ACK;
                        if (EE_ACK && !we_q) RDATA <= EE_DIN;
                        DONE0  <= GNT0;
                        DONE1  <= GNT1;
                        GNT0   <= 1'b0;
                        GNT1   <= 1'b0;
                        EE_DOE <= 1'b0;
                    end
                end
                S_DONE: begin
                    DONE0 <= 1'b0;
                    DONE1 <= 1'b0;
                end
            endcase
        end
    end

endmodule
